instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//   Program loader directly upstream of xilinx_one_port_ram_async (instruction memory).
//   Takes a byte stream from the UART receiver, packs 4 bytes into a 32-bit word
//   (first byte = MSB), and writes words to consecutive byte addresses 0x000, 0x004, ...
//   Load ends on HALT_WORD, which is itself written, or on memory overflow.
// PARAMETERS
//   ADDR_WIDTH  12             RAM byte-address width; must match the RAM instance
//   DATA_WIDTH  8              byte width; output word = DATA_WIDTH*4
//   HALT_WORD   32'hFFFF_FFFF  end-of-program marker
// PORTS
//   i_clk           in   1             single system clock, rising edge
//   i_rst_n         in   1             reset, asynchronous, active-low
//   i_start         in   1             1-cycle pulse: begin/restart load at address 0
//   i_rx_data       in   DATA_WIDTH    received byte
//   i_rx_valid      in   1             1-cycle strobe: i_rx_data valid
//   o_write_enable  out  1             to RAM i_write_enable
//   o_addr          out  ADDR_WIDTH    to RAM i_addr (byte address, word aligned)
//   o_data          out  DATA_WIDTH*4  to RAM i_data
//   o_busy          out  1             high in RECV/WRITE
//   o_done          out  1             high in DONE (HALT_WORD written)
//   o_error         out  1             high in ERROR (memory full, no HALT_WORD)
// BEHAVIOUR
//   Reset (i_rst_n=0, async): state IDLE; o_addr=0, o_data=0, byte_cnt=0; all 1-bit outs 0.
//   States: IDLE, RECV, WRITE, DONE, ERROR. o_busy/o_done/o_error/o_write_enable decode state.
//   IDLE : ignore i_rx_valid. i_start -> RECV, o_addr=0, byte_cnt=0.
//   RECV : on i_rx_valid: shift_reg = {shift_reg[23:0], i_rx_data}, byte_cnt++.
//          On the 4th byte: o_data <= assembled word, byte_cnt=0, -> WRITE.
//   WRITE: exactly 1 cycle, o_write_enable=1, o_addr/o_data stable.
//          Next: o_data==HALT_WORD -> DONE (o_addr holds).
//          else o_addr==2^ADDR_WIDTH-4 -> ERROR (o_addr holds).
//          else o_addr += 4, -> RECV.
//   Latency: 4th byte strobe sampled at edge N -> o_write_enable high for cycle N..N+1 only.
//   i_rx_valid during WRITE: byte accepted as byte 0 of the next word. No byte is lost.
//   DONE/ERROR: sticky. Ignore i_rx_valid. Leave only on i_start -> RECV, o_addr=0, byte_cnt=0.
//   i_start in RECV: abort and restart. o_addr=0, byte_cnt=0, partial word discarded.
//   i_start in WRITE: the current write completes. Next state RECV, o_addr=0, byte_cnt=0.
//   i_start together with i_rx_valid: i_start wins and the byte is dropped.
//   Reset mid-load: immediate return to IDLE. A write in progress is aborted and
//     o_write_enable drops asynchronously.
//   No address wrap ever. Overflow is reported via ERROR, never by writing 0x000 again.
// STRUCTURE
//   loader_pkg: state enum encoding, BYTES_PER_WORD=4, ADDR_STEP=4, default HALT_WORD.
//   Sub-module word_assembler: shift register plus 2-bit byte counter, with clear input.
//     Emits a word_valid pulse and the packed word.
//   Top holds the FSM and the address counter.
// TESTING (bench instantiates loader + xilinx_one_port_ram_async, reads RAM back)
//   1 i_start; bytes 12,34,56,78 -> one WE pulse, addr 0x000, RAM[0x000]=0x12345678.
//   2 i_start; 12,34,56,78,87,65,43,21,FF,FF,FF,FF -> RAM[0x000]=0x12345678,
//     RAM[0x004]=0x87654321, RAM[0x008]=0xFFFFFFFF, o_done=1, o_addr=0x008.
//   3 i_start; 1024 non-halt words -> last write at 0xFFC = DEADBEEF, o_error=1,
//     no WE afterwards.
//   4 i_start; bytes AA,BB; i_start; bytes 11,22,33,44 -> single write
//     RAM[0x000]=0x11223344, o_busy=1.
//   5 Drive i_rx_valid in the WRITE cycle of word 0 -> that byte becomes MSB of word at 0x004.
//   6 Assert i_rst_n=0 mid-word and in WRITE -> outputs 0 without a clock edge,
//     state IDLE, bytes ignored until i_start.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding, word geometry and the default end-of-program marker.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs a byte stream into words, first byte in the MSB position.
// word/word_valid are combinational so the FSM can capture on the 4th strobe.
module word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 valid,
  input  logic [DATA_WIDTH-1:0]                data,
  output logic                                 word_valid,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word
);

  logic [DATA_WIDTH*(BYTES_PER_WORD-1)-1:0] shift_reg;
  logic [1:0]                               byte_cnt;

  assign word_valid = valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_reg, data};

  // Counter wraps 3 -> 0 on the last byte, so the next word starts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (valid) begin
      shift_reg <= {shift_reg[DATA_WIDTH*(BYTES_PER_WORD-2)-1:0], data};
      byte_cnt  <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: bytes from the UART are packed into words and written to
// consecutive word-aligned RAM addresses until the halt word or memory full.
//
// state    | meaning
// IDLE     | waiting for i_start, bytes ignored
// RECV     | collecting bytes of the current word
// WRITE    | one-cycle RAM write of the assembled word
// DONE     | halt word written, sticky until i_start
// ERROR    | memory full without halt word, sticky until i_start
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int                                  ADDR_WIDTH = 12,
  parameter int                                  DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH*BYTES_PER_WORD-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [DATA_WIDTH-1:0]                i_rx_data,
  input  logic                                 i_rx_valid,
  output logic                                 o_write_enable,
  output logic [ADDR_WIDTH-1:0]                o_addr,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] o_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ~ADDR_WIDTH'(ADDR_STEP - 1);

  state_t                               state;
  logic                                 accept;
  logic                                 word_valid;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word;

  // A byte arriving during WRITE is already byte 0 of the next word.
  assign accept = i_rx_valid && ((state == ST_RECV) || (state == ST_WRITE));

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_assembler (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (i_start),
    .valid     (accept),
    .data      (i_rx_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      o_addr <= '0;
      o_data <= '0;
    end else if (i_start) begin
      state  <= ST_RECV;
      o_addr <= '0;
    end else begin
      case (state)
        ST_RECV: begin
          if (word_valid) begin
            o_data <= word;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (o_data == HALT_WORD) begin
            state <= ST_DONE;
          end else if (o_addr == ADDR_LAST) begin
            state <= ST_ERROR;
          end else begin
            o_addr <= o_addr + ADDR_INC;
            state  <= ST_RECV;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign o_write_enable = (state == ST_WRITE);
  assign o_busy         = (state == ST_RECV) || (state == ST_WRITE);
  assign o_done         = (state == ST_DONE);
  assign o_error        = (state == ST_ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios plus random traffic, checked
// cycle by cycle against a byte-queue reference model and a captured RAM image.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
  localparam int          LAST_ADDR = 4092;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        we;
  logic [11:0] addr;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_write_enable(we),
    .o_addr        (addr),
    .o_data        (data),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int max_gap  = 2;

  typedef enum int {M_IDLE, M_LOAD, M_DONE, M_ERROR} mode_t;
  mode_t       mode;
  bit          we_now;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [7:0]  q[$];

  logic [31:0] dut_ram[int];
  logic [31:0] ref_ram[int];
  int          dut_wr;

  // RAM stand-in: one capture per write-enable pulse, mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      dut_ram[int'(addr) >> 2] = data;
      dut_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode   = M_IDLE;
    we_now = 1'b0;
    m_addr = '0;
    m_data = '0;
    q.delete();
  endtask

  task automatic model_step(input bit st, input bit vld, input logic [7:0] d);
    bit was_load = (mode == M_LOAD);
    bit prev_we  = we_now;
    if (prev_we) ref_ram[int'(m_addr) >> 2] = m_data;
    we_now = 1'b0;
    if (st) begin
      mode   = M_LOAD;
      m_addr = '0;
      q.delete();
    end else if (was_load) begin
      if (prev_we) begin
        if (m_data == HALT) mode = M_DONE;
        else if (m_addr == LAST_ADDR) mode = M_ERROR;
        else m_addr = m_addr + 4;
      end
      if (vld) begin
        q.push_back(d);
        if (q.size() == 4) begin
          m_data = {q[0], q[1], q[2], q[3]};
          q.delete();
          we_now = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("we",    32'(we),    32'(we_now));
    check("busy",  32'(busy),  32'(mode == M_LOAD));
    check("done",  32'(done),  32'(mode == M_DONE));
    check("error", 32'(error), 32'(mode == M_ERROR));
    check("addr",  32'(addr),  m_addr);
    check("data",  data,       m_data);
  endtask

  task automatic tick(input bit st, input bit vld, input logic [7:0] d);
    @(negedge clk);
    compare_outputs();
    start    = st;
    rx_valid = vld;
    rx_data  = d;
    @(posedge clk);
    model_step(st, vld, d);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, max_gap)) tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic begin_test();
    dut_ram.delete();
    ref_ram.delete();
    dut_wr = 0;
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic compare_ram(input string tag);
    idle(3);
    check({tag, "_ram_count"}, 32'(dut_ram.num()), 32'(ref_ram.num()));
    foreach (ref_ram[k]) check({tag, "_ram"}, dut_ram.exists(k) ? dut_ram[k] : 32'hxxxx_xxxx, ref_ram[k]);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_we"},   32'(we),   32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_data"}, data,      32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word
    begin_test();
    send_word(32'h1234_5678);
    compare_ram("t1");
    check("t1_wr", 32'(dut_wr), 32'd1);
    check("t1_ram0", dut_ram[0], 32'h1234_5678);

    // 2: program terminated by the halt word
    begin_test();
    send_word(32'h1234_5678);
    send_word(32'h8765_4321);
    send_word(HALT);
    compare_ram("t2");
    check("t2_ram0", dut_ram[0], 32'h1234_5678);
    check("t2_ram1", dut_ram[1], 32'h8765_4321);
    check("t2_ram2", dut_ram[2], HALT);
    check("t2_done", 32'(done), 32'd1);
    check("t2_addr", 32'(addr), 32'h008);

    // 3: fill memory without halt word
    max_gap = 1;
    begin_test();
    for (int i = 0; i < 1023; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      send_word(w);
    end
    send_word(32'hDEAD_BEEF);
    idle(2);
    check("t3_last", dut_ram[1023], 32'hDEAD_BEEF);
    check("t3_error", 32'(error), 32'd1);
    check("t3_addr", 32'(addr), 32'hFFC);
    check("t3_wr", 32'(dut_wr), 32'd1024);
    send_word(32'h0102_0304);
    idle(2);
    check("t3_no_more_wr", 32'(dut_wr), 32'd1024);
    compare_ram("t3");
    max_gap = 2;

    // 4: restart mid-word; start with a simultaneous byte drops it
    begin_test();
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(1'b1, 1'b1, 8'h99);
    send_word(32'h1122_3344);
    idle(2);
    check("t4_wr", 32'(dut_wr), 32'd1);
    check("t4_ram0", dut_ram[0], 32'h1122_3344);
    check("t4_busy", 32'(busy), 32'd1);
    compare_ram("t4");

    // 5: byte during WRITE becomes MSB of the next word; start during WRITE
    begin_test();
    tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h02);
    tick(1'b0, 1'b1, 8'h03);
    tick(1'b0, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'hA5);
    tick(1'b0, 1'b1, 8'hB6);
    tick(1'b0, 1'b1, 8'hC7);
    tick(1'b0, 1'b1, 8'hD8);
    idle(2);
    check("t5_ram0", dut_ram[0], 32'h0102_0304);
    check("t5_ram1", dut_ram[1], 32'hA5B6_C7D8);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'h40 + 8'(i));
    tick(1'b1, 1'b0, 8'h00);
    idle(1);
    check("t5_restart_addr", 32'(addr), 32'd0);
    check("t5_wr", 32'(dut_wr), 32'd3);
    compare_ram("t5");

    // 6: asynchronous reset mid-word and during WRITE
    begin_test();
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    async_reset_check("t6_mid");
    send_word(32'h0BAD_F00D);
    idle(2);
    check("t6_ignored_wr", 32'(dut_wr), 32'd0);
    check("t6_ignored_busy", 32'(busy), 32'd0);
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'h70 + 8'(i));
    #1;
    check("t6_we_before", 32'(we), 32'd1);
    #1;
    async_reset_check("t6_write");
    idle(3);
    check("t6_aborted_wr", 32'(dut_wr), 32'd0);

    // 7: random traffic against the model
    begin_test();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom()));
    end
    compare_ram("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
